// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Purpose:
//   Pipeline-stage register that carries LANES fields of W bits between two
//   stages under a valid/ready handshake. A two-entry skid buffer (main + skid)
//   lets in_ready come straight from a flop, so it never depends on out_ready
//   through combinational logic. A synchronous flush turns the stage into a
//   bubble, and reset/flush load a per-lane reset vector so the PC lane
//   restarts at the boot address.
//
// Parameters:
//   LANES    number of W-bit fields; lane i is data bits [i*W +: W]
//   W        width of one lane
//   PC_LANE  lane that resets to RST_PC (all other lanes reset to 0)
//   RST_PC   reset/flush value of lane PC_LANE (low W bits used)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle (registered)
//   in_data    upstream fields, LANES*W bits
//   flush      synchronous kill of every held beat
//   out_valid  output beat present (registered)
//   out_ready  downstream accepts the output beat
//   out_data   head-of-stage fields (registered)
//   occupancy  number of held beats, 0..2 (registered)
// -----------------------------------------------------------------------------

// Structural invariants between the registered handshake outputs.
module pipe_stage_skid_chk (
  input logic       clk,
  input logic       rst,
  input logic       in_ready,
  input logic       out_valid,
  input logic [1:0] occupancy
);

  // Only three occupancy values exist.
  a_occ_range : assert property (@(posedge clk) disable iff (rst)
    occupancy != 2'd3);

  // in_ready is low exactly when both entries are held.
  a_ready_full : assert property (@(posedge clk) disable iff (rst)
    in_ready == (occupancy != 2'd2));

  // out_valid is high exactly when at least one entry is held.
  a_valid_occ : assert property (@(posedge clk) disable iff (rst)
    out_valid == (occupancy != 2'd0));

endmodule

module pipe_stage_skid #(
  parameter int          LANES   = 4,
  parameter int          W       = 32,
  parameter int          PC_LANE = 3,
  parameter logic [31:0] RST_PC  = 32'h0000_3008
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [1:0]         occupancy
);

  // Zero-extend the boot address so any W (narrower or wider than 32) works.
  localparam logic [W+31:0] RST_PC_EXT = {{W{1'b0}}, RST_PC};
  localparam logic [W-1:0]  RST_PC_W   = RST_PC_EXT[W-1:0];

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Reset/flush contents: boot address in the PC lane, zero (NOP) elsewhere.
  function automatic logic [LANES*W-1:0] reset_vector();
    logic [LANES*W-1:0] rv;
    rv = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == PC_LANE) begin
        rv[i*W +: W] = RST_PC_W;
      end else begin
        rv[i*W +: W] = '0;
      end
    end
    return rv;
  endfunction

  localparam logic [LANES*W-1:0] RST_VEC = reset_vector();

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [1:0]         occ_r;
  logic [LANES*W-1:0] main_r;
  logic [LANES*W-1:0] skid_r;

  logic               accept_s;
  logic               take_s;
  logic               main_load_s;
  logic               main_from_skid_s;
  logic               skid_load_s;
  logic               nxt_in_ready_s;
  logic               nxt_out_valid_s;
  logic [1:0]         nxt_occ_s;

  // Handshake qualifiers; both use only registered readiness/validity.
  assign accept_s = in_valid && in_ready_r;
  assign take_s   = out_valid_r && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !take_s) begin
            state_nxt_s = ST_FULL;
          end else if (!accept_s && take_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a take can move the state.
          if (take_s) begin
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Output/control decode: datapath load enables and next registered outputs.
  always_comb begin
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        main_load_s = accept_s;
      end
      ST_ONE: begin
        if (accept_s && take_s) begin
          main_load_s = 1'b1;
        end else if (accept_s) begin
          skid_load_s = 1'b1;
        end else begin
          main_load_s = 1'b0;
        end
      end
      ST_FULL: begin
        main_load_s      = take_s;
        main_from_skid_s = 1'b1;
      end
      default: begin
        main_load_s = 1'b0;
      end
    endcase

    nxt_in_ready_s  = (state_nxt_s != ST_FULL);
    nxt_out_valid_s = (state_nxt_s != ST_EMPTY);
    case (state_nxt_s)
      ST_EMPTY: nxt_occ_s = 2'd0;
      ST_ONE:   nxt_occ_s = 2'd1;
      ST_FULL:  nxt_occ_s = 2'd2;
      default:  nxt_occ_s = 2'd0;
    endcase
  end

  // Registered handshake/status outputs, updated on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
    end else begin
      in_ready_r  <= nxt_in_ready_s;
      out_valid_r <= nxt_out_valid_s;
      occ_r       <= nxt_occ_s;
    end
  end

  // Main and skid data registers; flush reloads the reset vector so a bubble
  // carries a NOP and the boot PC rather than stale fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r <= RST_VEC;
      skid_r <= RST_VEC;
    end else if (flush) begin
      main_r <= RST_VEC;
      skid_r <= RST_VEC;
    end else begin
      if (main_load_s) begin
        main_r <= main_from_skid_s ? skid_r : in_data;
      end else begin
        main_r <= main_r;
      end
      if (skid_load_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occ_r;

  pipe_stage_skid_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready_r),
    .out_valid (out_valid_r),
    .occupancy (occ_r)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed self-checking bench for pipe_stage_skid with default parameters
// (4 lanes of 32 bits, PC lane 3, boot address 0x3008). Beat payloads put
// value v in lane 0 and v+1..v+3 in lanes 1..3, so every lane is checked.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 128;
  localparam logic [DW-1:0] RV = {32'h0000_3008, 96'h0};

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int errors;
  int checks;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return {v + 32'd3, v + 32'd2, v + 32'd1, v};
  endfunction

  typedef struct {
    logic          iv;
    logic [31:0]   v;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic          ir;
    logic [1:0]    occ;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir,
                         input logic [1:0] occ, input logic [DW-1:0] exp);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(ov));
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(ir));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(occ));
    chk({tag, ".out_data"},  out_data,       exp);
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic step(input logic iv, input logic [31:0] v, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = mk(v);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;

    // Reset with no clock edge yet (first rising edge is at t=5).
    #2;
    chk_all("reset", 1'b0, 1'b1, 2'd0, RV);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming: 16 beats back to back, each visible one edge later.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 32'h100 + 32'(k), 1'b1, 1'b0);
      chk_all($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, mk(32'h100 + 32'(k)));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("stream_end", 1'b0, 1'b1, 2'd0, mk(32'h10F));

    // Table: backpressure, flush while FULL, flush with take, flush on accept.
    //            iv    v       ordy  fl    ov    ir    occ   expected out_data
    tbl[0]  = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h0A)}; // A in
    tbl[1]  = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(32'h0A)}; // B to skid
    tbl[2]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(32'h0A)}; // C held off
    tbl[3]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h0B)}; // A taken
    tbl[4]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h0C)}; // B taken, C in
    tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, mk(32'h0C)}; // C taken
    tbl[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, mk(32'h0C)}; // idle hold
    tbl[7]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h20)};
    tbl[8]  = '{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(32'h20)};
    tbl[9]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, RV};         // flush FULL, D offered
    tbl[10] = '{1'b1, 32'h23, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h23)}; // E flows
    tbl[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, mk(32'h23)};
    tbl[12] = '{1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h30)};
    tbl[13] = '{1'b1, 32'h31, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(32'h30)};
    tbl[14] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, RV};         // flush + take head
    tbl[15] = '{1'b1, 32'h32, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, mk(32'h32)}; // skid beat gone
    tbl[16] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, mk(32'h32)};
    tbl[17] = '{1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, RV};         // accept dropped by flush

    for (int i = 0; i < 18; i++) begin
      // Head beat must be offered when the flush-with-take edge comes.
      if (i == 14) begin
        chk("vec14.head_offered", DW'(out_valid), DW'(1'b1));
      end
      step(tbl[i].iv, tbl[i].v, tbl[i].ordy, tbl[i].fl);
      chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].ir, tbl[i].occ, tbl[i].exp);
    end

    // Reset mid-stream: fill to occupancy 2, then pulse rst between edges.
    step(1'b1, 32'h50, 1'b0, 1'b0);
    step(1'b1, 32'h51, 1'b0, 1'b0);
    chk_all("prerst", 1'b1, 1'b0, 2'd2, mk(32'h50));
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst", 1'b0, 1'b1, 2'd0, RV);
    rst = 1'b0;

    // Post-reset beats: no stale 0x50/0x51 may appear.
    step(1'b1, 32'h60, 1'b0, 1'b0);
    chk_all("postrst0", 1'b1, 1'b1, 2'd1, mk(32'h60));
    step(1'b1, 32'h61, 1'b0, 1'b0);
    chk_all("postrst1", 1'b1, 1'b0, 2'd2, mk(32'h60));
    step(1'b0, 32'h00, 1'b1, 1'b0);
    chk_all("postrst2", 1'b1, 1'b1, 2'd1, mk(32'h61));
    step(1'b0, 32'h00, 1'b1, 1'b0);
    chk_all("postrst3", 1'b0, 1'b1, 2'd0, mk(32'h61));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
